// File: rtl/btn_debounce_pkg.sv
// btn_debounce_pkg: button index map, channel count and default debounce length
// shared by the debouncer and the button-to-joystick mapper.
`default_nettype none

package btn_debounce_pkg;

  localparam int NUM_BTN                 = 5;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 280000;  // 10 ms at 28 MHz

  // Bit positions inside every button vector: {c,u,d,l,r} = [4:0]
  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;
  localparam int BTN_C = 4;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

endpackage

`default_nettype wire

// File: rtl/btn_debounce_if.sv
// btn_debounce_if: raw pad levels in, debounced levels and press/release strobes out.
`default_nettype none

interface btn_debounce_if;
  import btn_debounce_pkg::*;

  btn_vec_t btn_raw;
  btn_vec_t btn_db;
  btn_vec_t btn_press;
  btn_vec_t btn_release;

  modport master (
    output btn_raw,
    input  btn_db,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_db,
    output btn_press,
    output btn_release
  );

endinterface

`default_nettype wire

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel - 2-flop synchroniser, stable-level counter,
// accepted level and registered press/release strobes.
`default_nettype none

module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 280000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic press,
  output logic rel
);

  localparam int                   CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      rel   <= 1'b0;
      // Any agreement with the accepted level discards all progress so far
      if (sync2 == state) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        state <= sync2;
        cnt   <= '0;
        press <= sync2;
        rel   <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign db = state;

endmodule

`default_nettype wire

// File: rtl/btn_debounce.sv
// btn_debounce: NUM_BTN independent debounce channels feeding the joystick mapper
// levels and the menu/OSD press/release strobes.
`default_nettype none

module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  btn_debounce_if.slave   bus
);

  btn_vec_t db_vec;
  btn_vec_t press_vec;
  btn_vec_t rel_vec;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.btn_raw[i]),
      .db    (db_vec[i]),
      .press (press_vec[i]),
      .rel   (rel_vec[i])
    );
  end

  assign bus.btn_db      = db_vec;
  assign bus.btn_press   = press_vec;
  assign bus.btn_release = rel_vec;

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed scenarios plus randomized traffic, each cycle checked
// against a behavioural model of the debounce rules.
`default_nettype none

module tb_btn_debounce;
  import btn_debounce_pkg::*;

  localparam int DC = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  btn_debounce_if bus ();

  btn_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: pad level reaches the decision two edges late; a level is accepted once it
  // has disagreed with the accepted level on DC consecutive edges.
  btn_vec_t m_s1, m_s2, m_db, e_press, e_rel;
  int       run [NUM_BTN];

  function automatic void model_clear();
    m_s1 = '0; m_s2 = '0; m_db = '0; e_press = '0; e_rel = '0;
    for (int i = 0; i < NUM_BTN; i++) run[i] = 0;
  endfunction

  function automatic void model_edge(input btn_vec_t r);
    e_press = '0;
    e_rel   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (m_s2[i] != m_db[i]) begin
        run[i] = run[i] + 1;
        if (run[i] == DC) begin
          m_db[i]    = ~m_db[i];
          e_press[i] = m_db[i];
          e_rel[i]   = ~m_db[i];
          run[i]     = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = r;
  endfunction

  task automatic check(input string tag);
    vectors++;
    assert (bus.btn_db === m_db) else begin
      miscompares++;
      $error("FAIL %s btn_db observed %b expected %b", tag, bus.btn_db, m_db);
    end
    vectors++;
    assert (bus.btn_press === e_press) else begin
      miscompares++;
      $error("FAIL %s btn_press observed %b expected %b", tag, bus.btn_press, e_press);
    end
    vectors++;
    assert (bus.btn_release === e_rel) else begin
      miscompares++;
      $error("FAIL %s btn_release observed %b expected %b", tag, bus.btn_release, e_rel);
    end
  endtask

  task automatic chk(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic cyc(input btn_vec_t r, input string tag);
    bus.btn_raw = r;
    @(posedge clk);
    if (reset) model_edge(r);
    else       model_clear();
    #1;
    check(tag);
  endtask

  // Asynchronous assert away from any clock edge, hold n cycles, release mid-cycle
  task automatic do_reset(input int n);
    #2 reset = 1'b0;
    #1 model_clear();
    check("rst_async");
    repeat (n) cyc(bus.btn_raw, "rst_hold");
    reset = 1'b1;
  endtask

  initial begin
    int       first;
    int       np;
    btn_vec_t r;
    btn_vec_t sp, sr;

    bus.btn_raw = '1;
    model_clear();

    // 1: reset with all buttons held, then release
    do_reset(3);
    first = 0;
    for (int k = 1; k <= 14; k++) begin
      cyc(5'b11111, "s1_reset_release");
      if (first == 0 && bus.btn_db == 5'b11111) begin
        first = k;
        chk("s1_press_all", int'(bus.btn_press), 31);
      end
    end
    chk("s1_latency", first, 10);

    // 2: clean press on C
    bus.btn_raw = '0;
    do_reset(2);
    for (int k = 0; k < 3; k++) cyc(5'b00000, "s2_idle");
    first = 0;
    for (int k = 1; k <= 14; k++) begin
      cyc(5'b10000, "s2_press_c");
      if (first == 0 && bus.btn_db[BTN_C]) first = k;
    end
    chk("s2_latency", first, 10);
    chk("s2_others_low", int'(bus.btn_db[3:0]), 0);

    // 3: seven-cycle glitch on U is rejected, and a later hold gets no partial credit
    for (int k = 0; k < 7; k++) cyc(5'b11000, "s3_glitch");
    for (int k = 0; k < 12; k++) cyc(5'b10000, "s3_after");
    chk("s3_db_u_low", int'(bus.btn_db[BTN_U]), 0);
    first = 0;
    for (int k = 1; k <= 14; k++) begin
      cyc(5'b11000, "s3_hold_u");
      if (first == 0 && bus.btn_db[BTN_U]) first = k;
    end
    chk("s3_full_latency", first, 10);

    // 4: bouncing L, then a clean hold
    bus.btn_raw = '0;
    do_reset(2);
    np = 0;
    for (int c = 0; c < 30; c++) begin
      r = '0;
      r[BTN_L] = ((c / 3) % 2) == 0;
      cyc(r, "s4_bounce");
      if (bus.btn_press[BTN_L]) np++;
    end
    first = 0;
    for (int k = 1; k <= 14; k++) begin
      cyc(5'b00010, "s4_hold_l");
      if (bus.btn_press[BTN_L]) np++;
      if (first == 0 && bus.btn_db[BTN_L]) first = k;
    end
    chk("s4_one_press", np, 1);
    chk("s4_latency", first, 10);
    for (int k = 0; k < 12; k++) cyc(5'b00011, "s4_add_r");
    chk("s4_db_00011", int'(bus.btn_db), 3);

    // 5: release R and press D on the same cycle
    first = 0; sp = '0; sr = '0;
    for (int k = 1; k <= 14; k++) begin
      cyc(5'b00110, "s5_swap");
      if (first == 0 && bus.btn_db == 5'b00110) begin
        first = k; sp = bus.btn_press; sr = bus.btn_release;
      end
    end
    chk("s5_latency", first, 10);
    chk("s5_press", int'(sp), 4);
    chk("s5_release", int'(sr), 1);

    // 6: reset while C is five counts into its press
    for (int k = 0; k < 7; k++) cyc(5'b10110, "s6_counting");
    chk("s6_not_yet", int'(bus.btn_db[BTN_C]), 0);
    do_reset(3);
    for (int k = 0; k < 12; k++) cyc(5'b10110, "s6_after_reset");

    // Randomized traffic: slow random flips give both glitches and accepted edges
    r = bus.btn_raw;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NUM_BTN; i++)
        if ($urandom_range(11) == 0) r[i] = ~r[i];
      if ($urandom_range(299) == 0) do_reset($urandom_range(3));
      cyc(r, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
